booth_mac_acc: RTL

BOOTH_MAC_ACC -- requirements
Module: booth_mac_acc

---
 rtl/booth_mac_acc.sv | 105 ++++++++++
 1 files changed

// File: rtl/booth_mac_acc.sv
// Accumulates N_TERMS signed Booth-multiplier products into a saturating
// ACC_W-bit sum and publishes the result with a one-cycle done pulse.
module booth_mac_acc #(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             done,
    output logic             busy,
    output logic             ovf
);

    // state | meaning
    // IDLE  | waiting for start; outputs hold the last result
    // ACC   | accepting products until N_TERMS have been summed
    // DONE  | one cycle: done pulse, acc_out/ovf freshly updated

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(N_TERMS);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             run_ovf;

    logic [ACC_W:0]   sum;
    logic             clamp;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // One guard bit is enough: both operands fit in ACC_W bits.
    always_comb begin
        sum     = {acc[ACC_W-1], acc} + {{(ACC_W-7){prod[7]}}, prod};
        clamp   = sum[ACC_W] ^ sum[ACC_W-1];
        acc_nxt = sum[ACC_W-1:0];
        if (clamp) begin
            acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        cnt_nxt = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            run_ovf    <= 1'b0;
            acc_out    <= '0;
            ovf        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            prod_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc        <= '0;
                        cnt        <= '0;
                        run_ovf    <= 1'b0;
                        prod_ready <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ACC;
                    end
                end
                ACC: begin
                    if (prod_valid) begin
                        acc     <= acc_nxt;
                        cnt     <= cnt_nxt;
                        run_ovf <= run_ovf | clamp;
                        // Publish on the final transfer so the result is visible during DONE.
                        if (cnt_nxt == LAST) begin
                            acc_out    <= acc_nxt;
                            ovf        <= run_ovf | clamp;
                            done       <= 1'b1;
                            prod_ready <= 1'b0;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    prod_ready <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
